// File: rtl/note_track_pkg.sv
// Shared types and defaults for the note-track sequencer and its step timer.
package note_track_pkg;
   localparam int TRACK_LEN_DEF  = 100;
   localparam int MIN_PERIOD_DEF = 3;
   // RUN needs at least one cycle, followed by one FETCH cycle and one SHIFT cycle.
   localparam int STEP_OVERHEAD  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_FETCH,
      S_SHIFT,
      S_DONE
   } state_t;
endpackage

// File: rtl/note_track_sequencer_step_timer.sv
// Beat-step counter: clear, enable, and terminal-count compare against term.
module step_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                en,
   input  logic [PERIOD_W-1:0] term,
   output logic                tc
);
   logic [PERIOD_W-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  count <= '0;
      else if (clr)  count <= '0;
      else if (en)   count <= count + 1'b1;
   end

   assign tc = (count == term);
endmodule

// File: rtl/note_track_sequencer.sv
// Drives one lane's note-track shifter: clear, shift the chart in at the step
// period, flush TRACK_LEN zeros, then report done.
module note_track_sequencer
   import note_track_pkg::*;
#(
   parameter int TRACK_LEN  = TRACK_LEN_DEF,
   parameter int ADDR_W     = 16,
   parameter int PERIOD_W   = 24,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 pause,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    song_len,
   input  logic [PERIOD_W-1:0]  step_period,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic                 rom_data,
   output logic [TRACK_LEN-1:0] sh_load_val,
   output logic                 sh_load_n,
   output logic                 sh_shift,
   output logic                 sh_in,
   output logic                 step_pulse,
   output logic [ADDR_W:0]      step_count,
   output logic                 busy,
   output logic                 done
);
   state_t              state, state_nx;
   logic [ADDR_W-1:0]   len_q;
   logic [PERIOD_W-1:0] period_q;
   logic [ADDR_W:0]     count_inc, total;
   logic                start_ok, tmr_clr, tmr_en, tmr_tc, fetch_go;

   assign sh_load_val = '0;
   assign count_inc   = step_count + 1'b1;
   assign total       = {1'b0, len_q} + (ADDR_W+1)'(TRACK_LEN);
   assign start_ok    = start && !abort && (state == S_IDLE || state == S_DONE);

   // Timer only runs while a step is being timed; FETCH keeps counting so a
   // step that reached FETCH is immune to pause.
   assign tmr_clr  = abort || !(state == S_RUN || state == S_FETCH);
   assign tmr_en   = (state == S_RUN && !pause) || state == S_FETCH;
   assign fetch_go = tmr_tc && state == S_RUN && !pause;

   step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .term    (period_q - PERIOD_W'(STEP_OVERHEAD)),
      .tc      (tmr_tc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         len_q      <= '0;
         period_q   <= PERIOD_W'(MIN_PERIOD);
         step_count <= '0;
         rom_addr   <= '0;
      end else begin
         state <= state_nx;
         if (abort) begin
            rom_addr <= '0;
         end else if (start_ok) begin
            len_q      <= song_len;
            period_q   <= (step_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                : step_period;
            step_count <= '0;
            rom_addr   <= '0;
         end else if (state == S_SHIFT) begin
            step_count <= count_inc;
            rom_addr   <= count_inc[ADDR_W-1:0];
         end
      end
   end

   always_comb begin
      state_nx   = state;
      sh_load_n  = 1'b1;
      sh_shift   = 1'b0;
      sh_in      = 1'b0;
      step_pulse = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_CLEAR;
         S_CLEAR: begin
            sh_load_n = 1'b0;
            busy      = 1'b1;
            state_nx  = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (fetch_go) state_nx = S_FETCH;
         end
         S_FETCH: begin
            busy     = 1'b1;
            state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            busy       = 1'b1;
            sh_shift   = 1'b1;
            step_pulse = 1'b1;
            sh_in      = (step_count < {1'b0, len_q}) ? rom_data : 1'b0;
            state_nx   = (count_inc == total) ? S_DONE : S_RUN;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nx = S_CLEAR;
         end
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end
endmodule

// File: tb/tb_note_track_sequencer.sv
// Directed-plus-random bench: expected step timing and track bits come from
// the song rules (period clamp, pause credit, chart then zero flush).
module tb_note_track_sequencer;
   logic         clk = 1'b0;
   logic         reset_n, start, pause, abort, rom_data;
   logic [15:0]  song_len, rom_addr;
   logic [23:0]  step_period;
   logic [99:0]  sh_load_val;
   logic         sh_load_n, sh_shift, sh_in, step_pulse, busy, done;
   logic [16:0]  step_count;
   logic         rom_bits [16];
   int           n_cmp = 0;
   int           n_err = 0;

   note_track_sequencer dut (
      .clock       (clk),
      .reset_n     (reset_n),
      .start       (start),
      .pause       (pause),
      .abort       (abort),
      .song_len    (song_len),
      .step_period (step_period),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .sh_load_val (sh_load_val),
      .sh_load_n   (sh_load_n),
      .sh_shift    (sh_shift),
      .sh_in       (sh_in),
      .step_pulse  (step_pulse),
      .step_count  (step_count),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Chart ROM: one-cycle read latency.
   always @(posedge clk) rom_data <= rom_bits[rom_addr[3:0]];

   initial begin
      #600000;
      $display("FAIL watchdog: bench did not complete (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic randomize_rom();
      for (int i = 0; i < 16; i++) rom_bits[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_done"},   32'(done), 0);
      check({tag, "_load_n"}, 32'(sh_load_n), 1);
      check({tag, "_shift"},  32'({sh_shift, step_pulse, sh_in}), 0);
      check({tag, "_addr"},   32'(rom_addr), 0);
   endtask

   task automatic launch(input int len, input int per);
      @(negedge clk);
      song_len    = 16'(len);
      step_period = 24'(per);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("clear_load_n", 32'(sh_load_n), 0);
      check("clear_shift",  32'(sh_shift), 0);
      check("clear_busy",   32'(busy), 1);
      check("clear_count",  32'(step_count), 0);
   endtask

   // pm: 0 plain, 1 pause for plen cycles in RUN, 2 pause raised in FETCH,
   // 3 start pulse during RUN (must be ignored).
   task automatic wait_pulse(input int k, input int exp_gap, input logic exp_bit,
                             input int pm, input int plen, input int eff);
      int gap = 0;
      while (1) begin
         @(negedge clk);
         gap++;
         if (pm == 1 && gap == 2)        pause = 1'b1;
         if (pm == 1 && gap == 2 + plen) pause = 1'b0;
         if (pm == 2 && gap == eff - 1)  pause = 1'b1;
         if (pm == 2 && gap == eff)      pause = 1'b0;
         if (pm == 3 && gap == 1) begin start = 1'b1; song_len = 16'd5; end
         if (pm == 3 && gap == 2)        start = 1'b0;
         if (sh_shift || gap > exp_gap + 5) break;
      end
      pause = 1'b0;
      start = 1'b0;
      check($sformatf("gap_step%0d", k), 32'(gap), 32'(exp_gap));
      check($sformatf("sh_in_step%0d", k), 32'(sh_in), 32'(exp_bit));
      check($sformatf("pulse_step%0d", k), 32'({step_pulse, sh_load_n}), 32'b11);
   endtask

   task automatic play(input int len, input int per, input int ps_run,
                       input int ps_fetch, input int ps_start, input int plen);
      int   eff = (per < 3) ? 3 : per;
      int   pm, exp_gap;
      logic b;
      launch(len, per);
      for (int k = 0; k < len + 100; k++) begin
         pm = (k == ps_run) ? 1 : (k == ps_fetch) ? 2 : (k == ps_start) ? 3 : 0;
         exp_gap = eff + ((pm == 1) ? plen : 0);
         b = 1'b0;
         if (k < len) b = rom_bits[k];
         wait_pulse(k, exp_gap, b, pm, plen, eff);
      end
      @(negedge clk);
      check("end_done",  32'(done), 1);
      check("end_busy",  32'(busy), 0);
      check("end_count", 32'(step_count), 32'(len + 100));
   endtask

   initial begin
      int per, shifts;
      logic b;
      reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
      song_len = '0; step_period = '0;
      for (int i = 0; i < 16; i++) rom_bits[i] = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_count", 32'(step_count), 0);
      check("load_val", 32'(|sh_load_val), 0);
      reset_n = 1'b1;

      // Fixed chart 1,0,1,1 at period 10.
      rom_bits[0] = 1'b1; rom_bits[1] = 1'b0; rom_bits[2] = 1'b1; rom_bits[3] = 1'b1;
      play(4, 10, -1, -1, -1, 0);

      // Restart from DONE, period clamped to 3, stray start during RUN.
      randomize_rom();
      play($urandom_range(1, 8), 1, -1, -1, 1, 0);

      // 50-cycle pause in RUN, then pause raised during FETCH.
      randomize_rom();
      play($urandom_range(5, 12), 20, 2, 4, -1, 50);

      // Empty chart: flush only.
      play(0, $urandom_range(3, 6), -1, -1, -1, 0);

      // Abort after 7 steps, with start in the same cycle.
      randomize_rom();
      per = $urandom_range(4, 9);
      launch(12, per);
      for (int k = 0; k < 7; k++) wait_pulse(k, per, rom_bits[k], 0, 0, per);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check_idle("abort");
      check("abort_count", 32'(step_count), 7);
      shifts = 0;
      repeat (3 * per) begin
         @(negedge clk);
         if (sh_shift) shifts++;
      end
      check("abort_no_shift", 32'(shifts), 0);
      check("abort_stays_idle", 32'(busy), 0);

      // Asynchronous reset while a shift is in progress.
      randomize_rom();
      launch(3, 5);
      for (int k = 0; k < 3; k++) wait_pulse(k, 5, rom_bits[k], 0, 0, 5);
      #1 reset_n = 1'b0;
      #1;
      check_idle("async_rst");
      check("async_rst_count", 32'(step_count), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
